t05_decomp_ctrl: RTL and testbench

Top-level sequencer for the decompression path. Runs t05_hd_decode (header/codebook phase), then the body decoder (bitstream phase), until the decoded character count equals the header's tot_chars. Owns the single SPI byte-read channel and hands it to whichever decoder is active. Provides byte fetch with handshake, phase gating, progress counters and a stall watchdog.

---
 rtl/t05_decomp_pkg.sv | 17 +
 rtl/t05_spi_fetch.sv | 18 +
 rtl/t05_decomp_ctrl.sv | 83 ++++++++
 tb/tb_t05_decomp_ctrl.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/t05_decomp_pkg.sv
// t05_decomp_pkg: controller state encoding, default limits and a saturating increment
package t05_decomp_pkg;
  typedef enum logic [3:0] {
    ST_IDLE     = 4'd0,
    ST_HEADER   = 4'd1,
    ST_HD_FETCH = 4'd2,
    ST_DECODE   = 4'd3,
    ST_BD_FETCH = 4'd4,
    ST_DONE     = 4'd5,
    ST_ERROR    = 4'd6
  } ctrl_state_t;
  localparam int DEF_TIMEOUT_CYCLES = 4096;
  localparam int DEF_MAX_HEADER_BYTES = 1024;
  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return &v ? v : v + 32'd1;
  endfunction
endpackage

// File: rtl/t05_spi_fetch.sv
// t05_spi_fetch: SPI ack acceptance and stall watchdog (active=fetch in progress, take=ack accepted, expired=wait budget used up)
module t05_spi_fetch import t05_decomp_pkg::*; #(
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic clk,
  input  logic rst,
  input  logic active,
  input  logic ack,
  output logic take,
  output logic expired
);
  logic [31:0] wait_cnt;
  always_ff @(posedge clk)
    if (rst || !active) wait_cnt <= '0;
    else wait_cnt <= sat_inc(wait_cnt);
  assign take = active && ack;
  assign expired = active && !ack && wait_cnt >= 32'(TIMEOUT_CYCLES - 1);
endmodule

// File: rtl/t05_decomp_ctrl.sv
// t05_decomp_ctrl: header-then-body decompression sequencer owning the SPI byte channel (start/busy/done/error, spi_rd_*, hd_* and bd_* decoder links, chars_done/bytes_read counters)
module t05_decomp_ctrl import t05_decomp_pkg::*; #(
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
  parameter int MAX_HEADER_BYTES = DEF_MAX_HEADER_BYTES
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic        spi_rd_req,
  input  logic        spi_rd_ack,
  input  logic [7:0]  spi_rd_data,
  output logic        hd_enable,
  input  logic        hd_SPI_read_en,
  output logic [7:0]  hd_SPI_data,
  input  logic        hd_finished,
  input  logic [31:0] hd_tot_chars,
  output logic        bd_enable,
  input  logic        bd_rd_en,
  output logic [7:0]  bd_rd_data,
  output logic        bd_rd_valid,
  input  logic        bd_char_valid,
  output logic [31:0] chars_done,
  output logic [31:0] bytes_read
);
  ctrl_state_t st, st_n;
  logic [31:0] tot_chars, hdr_cnt;
  logic take, expired, fetching, char_hit, fin, restart;
  assign fetching = st == ST_HD_FETCH || st == ST_BD_FETCH;
  assign char_hit = bd_char_valid && (st == ST_DECODE || st == ST_BD_FETCH);
  assign fin = char_hit && sat_inc(chars_done) == tot_chars;
  assign restart = start && (st == ST_IDLE || st == ST_DONE || st == ST_ERROR);
  t05_spi_fetch #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_fetch (
    .clk(clk), .rst(rst), .active(fetching), .ack(spi_rd_ack), .take(take), .expired(expired)
  );
  always_comb begin
    st_n = st;
    case (st)
      ST_IDLE, ST_DONE, ST_ERROR: st_n = restart ? ST_HEADER : st;
      ST_HEADER: st_n = hd_finished ? (hd_tot_chars == '0 ? ST_DONE : ST_DECODE) :
                        hdr_cnt >= 32'(MAX_HEADER_BYTES) ? ST_ERROR :
                        hd_SPI_read_en ? ST_HD_FETCH : st;
      ST_HD_FETCH: st_n = take ? ST_HEADER : expired ? ST_ERROR : st;
      ST_DECODE:   st_n = fin ? ST_DONE : bd_rd_en ? ST_BD_FETCH : st;
      ST_BD_FETCH: st_n = fin ? ST_DONE : take ? ST_DECODE : expired ? ST_ERROR : st;
      default:     st_n = ST_IDLE;
    endcase
  end
  always_ff @(posedge clk)
    if (rst) begin
      st <= ST_IDLE;
      tot_chars <= '0;
      hdr_cnt <= '0;
      chars_done <= '0;
      bytes_read <= '0;
      hd_SPI_data <= '0;
      bd_rd_data <= '0;
      bd_rd_valid <= 1'b0;
    end else begin
      st <= st_n;
      bd_rd_valid <= st == ST_BD_FETCH && take && !fin;
      if (st == ST_HEADER && hd_finished) tot_chars <= hd_tot_chars;
      if (st == ST_HD_FETCH && take) hd_SPI_data <= spi_rd_data;
      if (st == ST_BD_FETCH && take && !fin) bd_rd_data <= spi_rd_data;
      if (restart) begin
        hdr_cnt <= '0;
        chars_done <= '0;
        bytes_read <= '0;
      end else begin
        if (st == ST_HD_FETCH && take) hdr_cnt <= sat_inc(hdr_cnt);
        if (take && !fin) bytes_read <= sat_inc(bytes_read);
        if (char_hit) chars_done <= sat_inc(chars_done);
      end
    end
  assign busy = st inside {ST_HEADER, ST_HD_FETCH, ST_DECODE, ST_BD_FETCH};
  assign done = st == ST_DONE;
  assign error = st == ST_ERROR;
  assign hd_enable = st == ST_HEADER;
  assign bd_enable = st == ST_DECODE || st == ST_BD_FETCH;
  assign spi_rd_req = fetching;
endmodule

// File: tb/tb_t05_decomp_ctrl.sv
// tb_t05_decomp_ctrl: directed self-checking bench for t05_decomp_ctrl
module tb_t05_decomp_ctrl;
  logic clk = 1'b0, rst = 1'b1, start = 1'b0, spi_rd_ack = 1'b0;
  logic hd_SPI_read_en = 1'b0, hd_finished = 1'b0, bd_rd_en = 1'b0, bd_char_valid = 1'b0;
  logic [7:0] spi_rd_data = '0;
  logic [31:0] hd_tot_chars = '0;
  logic busy, done, error, spi_rd_req, hd_enable, bd_enable, bd_rd_valid;
  logic [7:0] hd_SPI_data, bd_rd_data;
  logic [31:0] chars_done, bytes_read;
  int n_checks = 0, n_fail = 0;
  localparam logic [6:0] F_IDLE = 7'b0000000, F_HDR = 7'b1000100, F_HDF = 7'b1001000;
  localparam logic [6:0] F_DEC = 7'b1000010, F_BDF = 7'b1001010, F_DECV = 7'b1000011;
  localparam logic [6:0] F_DONE = 7'b0100000, F_ERR = 7'b0010000;
  always #5 clk = ~clk;
  t05_decomp_ctrl #(.TIMEOUT_CYCLES(16), .MAX_HEADER_BYTES(4)) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done), .error(error),
    .spi_rd_req(spi_rd_req), .spi_rd_ack(spi_rd_ack), .spi_rd_data(spi_rd_data),
    .hd_enable(hd_enable), .hd_SPI_read_en(hd_SPI_read_en), .hd_SPI_data(hd_SPI_data),
    .hd_finished(hd_finished), .hd_tot_chars(hd_tot_chars), .bd_enable(bd_enable),
    .bd_rd_en(bd_rd_en), .bd_rd_data(bd_rd_data), .bd_rd_valid(bd_rd_valid),
    .bd_char_valid(bd_char_valid), .chars_done(chars_done), .bytes_read(bytes_read)
  );
  function automatic logic [6:0] flags();
    return {busy, done, error, spi_rd_req, hd_enable, bd_enable, bd_rd_valid};
  endfunction
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask
  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask
  task automatic pulse_char();
    bd_char_valid = 1'b1;
    tick();
    bd_char_valid = 1'b0;
  endtask
  task automatic hd_fetch(input logic [7:0] b);
    hd_SPI_read_en = 1'b1;
    tick();
    hd_SPI_read_en = 1'b0;
    check("hd_req", 32'(flags()), 32'(F_HDF));
    tick();
    check("hd_wait", 32'(flags()), 32'(F_HDF));
    spi_rd_data = b;
    spi_rd_ack = 1'b1;
    tick();
    spi_rd_ack = 1'b0;
    check("hd_ret", 32'(flags()), 32'(F_HDR));
    check("hd_data", 32'(hd_SPI_data), 32'(b));
  endtask
  task automatic bd_fetch(input logic [7:0] b);
    bd_rd_en = 1'b1;
    tick();
    bd_rd_en = 1'b0;
    check("bd_req", 32'(flags()), 32'(F_BDF));
    tick();
    check("bd_wait", 32'(flags()), 32'(F_BDF));
    spi_rd_data = b;
    spi_rd_ack = 1'b1;
    tick();
    spi_rd_ack = 1'b0;
    check("bd_valid", 32'(flags()), 32'(F_DECV));
    check("bd_data", 32'(bd_rd_data), 32'(b));
    tick();
    check("bd_valid_end", 32'(flags()), 32'(F_DEC));
  endtask
  initial begin
    #1_000_000;
    $display("FAIL global_timeout: got no end, expected end of test");
    $fatal(1);
  end
  initial begin
    tick();
    tick();
    rst = 1'b0;
    check("rst_flags", 32'(flags()), 32'(F_IDLE));
    check("rst_chars", chars_done, 0);
    check("rst_bytes", bytes_read, 0);
    check("rst_hd_data", 32'(hd_SPI_data), 0);
    check("rst_bd_data", 32'(bd_rd_data), 0);
    pulse_start();
    check("t1_header", 32'(flags()), 32'(F_HDR));
    hd_fetch(8'hA1);
    hd_fetch(8'hB2);
    hd_fetch(8'hC3);
    check("t1_hd_bytes", bytes_read, 3);
    hd_finished = 1'b1;
    hd_tot_chars = 32'd5;
    tick();
    hd_finished = 1'b0;
    check("t1_decode", 32'(flags()), 32'(F_DEC));
    pulse_char();
    check("t1_chars1", chars_done, 1);
    bd_fetch(8'h5A);
    pulse_char();
    pulse_char();
    check("t1_chars3", chars_done, 3);
    bd_fetch(8'h6B);
    pulse_char();
    check("t1_chars4", chars_done, 4);
    check("t1_not_done", 32'(flags()), 32'(F_DEC));
    pulse_char();
    check("t1_done", 32'(flags()), 32'(F_DONE));
    check("t1_chars5", chars_done, 5);
    check("t1_bytes5", bytes_read, 5);
    tick();
    check("t1_done_hold", 32'(flags()), 32'(F_DONE));
    check("t1_chars_hold", chars_done, 5);
    pulse_start();
    check("t2_header", 32'(flags()), 32'(F_HDR));
    check("t2_chars_clr", chars_done, 0);
    check("t2_bytes_clr", bytes_read, 0);
    hd_finished = 1'b1;
    hd_tot_chars = 32'd0;
    tick();
    hd_finished = 1'b0;
    check("t2_zero_done", 32'(flags()), 32'(F_DONE));
    pulse_start();
    hd_fetch(8'h11);
    check("t3_bytes1", bytes_read, 1);
    hd_SPI_read_en = 1'b1;
    tick();
    hd_SPI_read_en = 1'b0;
    check("t3_fetch", 32'(flags()), 32'(F_HDF));
    repeat (11) tick();
    check("t3_still_wait", 32'(flags()), 32'(F_HDF));
    repeat (7) tick();
    check("t3_timeout", 32'(flags()), 32'(F_ERR));
    check("t3_bytes_hold", bytes_read, 1);
    pulse_start();
    check("t3_restart", 32'(flags()), 32'(F_HDR));
    check("t3_bytes_clr", bytes_read, 0);
    hd_finished = 1'b1;
    hd_tot_chars = 32'd3;
    tick();
    hd_finished = 1'b0;
    check("t4_decode", 32'(flags()), 32'(F_DEC));
    bd_fetch(8'h77);
    check("t4_bytes1", bytes_read, 1);
    bd_rd_en = 1'b1;
    tick();
    bd_rd_en = 1'b0;
    check("t4_bd_fetch", 32'(flags()), 32'(F_BDF));
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("t4_rst_flags", 32'(flags()), 32'(F_IDLE));
    check("t4_rst_bytes", bytes_read, 0);
    check("t4_rst_bd_data", 32'(bd_rd_data), 0);
    check("t4_rst_hd_data", 32'(hd_SPI_data), 0);
    spi_rd_data = 8'hFF;
    spi_rd_ack = 1'b1;
    tick();
    spi_rd_ack = 1'b0;
    check("t4_late_flags", 32'(flags()), 32'(F_IDLE));
    check("t4_late_data", 32'(bd_rd_data), 0);
    check("t4_late_bytes", bytes_read, 0);
    pulse_start();
    check("t5_header", 32'(flags()), 32'(F_HDR));
    hd_finished = 1'b1;
    hd_SPI_read_en = 1'b1;
    hd_tot_chars = 32'd2;
    tick();
    hd_finished = 1'b0;
    hd_SPI_read_en = 1'b0;
    check("t5_fin_prio", 32'(flags()), 32'(F_DEC));
    start = 1'b1;
    bd_char_valid = 1'b1;
    tick();
    start = 1'b0;
    bd_char_valid = 1'b0;
    check("t5_start_ign", 32'(flags()), 32'(F_DEC));
    check("t5_chars1", chars_done, 1);
    pulse_char();
    check("t5_done", 32'(flags()), 32'(F_DONE));
    check("t5_chars2", chars_done, 2);
    pulse_start();
    hd_fetch(8'h01);
    hd_fetch(8'h02);
    hd_fetch(8'h03);
    hd_fetch(8'h04);
    check("t6_bytes4", bytes_read, 4);
    hd_SPI_read_en = 1'b1;
    tick();
    hd_SPI_read_en = 1'b0;
    check("t6_overflow", 32'(flags()), 32'(F_ERR));
    tick();
    check("t6_err_hold", 32'(flags()), 32'(F_ERR));
    check("t6_bytes_hold", bytes_read, 4);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
